// File: rtl/fifo_drain_ctrl_if.sv
// FIFO-read and downstream valid/ready signals for fifo_drain_ctrl.
// The master modport is the drain controller; slave is the FIFO plus consumer side.
interface fifo_drain_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              fifo_is_empty;
  logic [DATA_W-1:0] fifo_read_data;
  logic              fifo_read_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  fifo_is_empty,
    input  fifo_read_data,
    input  out_ready,
    output fifo_read_ctrl,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_is_empty,
    output fifo_read_data,
    output out_ready,
    input  fifo_read_ctrl,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Reader-side controller: pulls words from a 1-cycle-latency FIFO into a small output buffer.
// Define FIFO_DRAIN_CTRL_STATS_EN to build the saturating stall_cycles counter.
module fifo_drain_ctrl #(
  parameter int DATA_W     = 8,
  parameter int OBUF_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  fifo_drain_ctrl_if.master   bus,
  output logic [CNT_W-1:0]    words_out,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(OBUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OBUF_DEPTH - 1);

  logic [DATA_W-1:0] obuf [OBUF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [OCC_W-1:0]  occ;
  logic              inflight;
  logic              discard;
  logic              deq;
  logic              capture;
  logic              room;
  logic [OCC_W-1:0]  committed;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = obuf[head];
  assign deq           = bus.out_valid & bus.out_ready;
  assign capture       = inflight & ~discard & ~flush;

  // Words already owned (buffered or returning) must leave a free slot after this cycle's deq.
  assign committed          = occ + OCC_W'(inflight);
  assign room               = committed < (DEPTH_C + OCC_W'(deq));
  assign bus.fifo_read_ctrl = ~rst & ~flush & ~bus.fifo_is_empty & room;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      inflight  <= 1'b0;
      discard   <= 1'b0;
      words_out <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        obuf[i] <= '0;
      end
    end else begin
      inflight <= bus.fifo_read_ctrl;
      discard  <= flush & bus.fifo_read_ctrl;
      if (deq) begin
        words_out <= words_out + CNT_W'(1);
      end
      if (flush) begin
        head <= '0;
        tail <= '0;
        occ  <= '0;
      end else begin
        if (capture) begin
          obuf[tail] <= bus.fifo_read_data;
          tail       <= ptr_next(tail);
        end
        if (deq) begin
          head <= ptr_next(head);
        end
        occ <= occ + OCC_W'(capture) - OCC_W'(deq);
      end
    end
  end

`ifdef FIFO_DRAIN_CTRL_STATS_EN
  // Backpressure counter survives flush so it reflects the whole run since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: directed vector table, hand sequences,
// and a randomized run scored against a queue-based model of the delivered stream.
module tb_fifo_drain_ctrl;

  localparam int DEPTH = 2;
  localparam int DW    = 8;
  localparam int CW    = 16;
`ifdef FIFO_DRAIN_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic          push_en;
    logic [DW-1:0] push_data;
    logic          ready;
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_words;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } pend_t;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          out_ready;
  logic          mon_en;
  logic [CW-1:0] words_out;
  logic [CW-1:0] stall_cycles;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic [DW-1:0] fifo_q [$];
  int            checks   = 0;
  int            failures = 0;

  fifo_drain_ctrl_if #(.DATA_W(DW)) dif ();

  assign dif.fifo_is_empty  = fifo_empty;
  assign dif.fifo_read_data = fifo_rdata;
  assign dif.out_ready      = out_ready;

  fifo_drain_ctrl #(
    .DATA_W    (DW),
    .OBUF_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (dif),
    .words_out   (words_out),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: registered empty flag and registered read data, cleared by the shared rst.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_rdata <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (dif.fifo_read_ctrl && fifo_q.size() != 0) begin
        fifo_rdata <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy, input logic fl,
                                input logic pe, input logic [DW-1:0] pd);
    @(negedge clk);
    rst       = r;
    out_ready = rdy;
    flush     = fl;
    if (pe) fifo_q.push_back(pd);
    #2;
  endtask

  // Reference model: every word strobed out of the FIFO becomes deliverable two cycles later, in order.
  pend_t         pend_q [$];
  int            mon_cyc = 0;
  logic [CW-1:0] exp_words;
  logic [CW-1:0] exp_stall;
  logic          m_valid;
  logic          m_deq;
  logic          m_rd;

  always begin
    @(negedge clk);
    #2;
    mon_cyc++;
    m_valid = 1'b0;
    if (pend_q.size() != 0) m_valid = (pend_q[0].avail <= mon_cyc);
    m_deq = m_valid && out_ready;
    m_rd  = !rst && !flush && !fifo_empty && ((pend_q.size() - int'(m_deq)) < DEPTH);
    if (mon_en) begin
      check_output("mon_read_ctrl", 32'(dif.fifo_read_ctrl), 32'(m_rd));
      check_output("mon_read_while_empty", 32'(dif.fifo_read_ctrl & fifo_empty), 32'd0);
      check_output("mon_out_valid", 32'(dif.out_valid), 32'(m_valid));
      if (m_valid) check_output("mon_out_data", 32'(dif.out_data), 32'(pend_q[0].data));
      check_output("mon_words_out", 32'(words_out), 32'(exp_words));
      check_output("mon_stall_cycles", 32'(stall_cycles), 32'(exp_stall));
    end
    if (rst) begin
      pend_q.delete();
      exp_words = '0;
      exp_stall = '0;
    end else begin
      if (m_deq) begin
        pend_q.delete(0);
        exp_words++;
      end
      if (STATS && m_valid && !out_ready && exp_stall != '1) exp_stall++;
      if (flush) pend_q.delete();
      else if (m_rd && fifo_q.size() != 0) pend_q.push_back('{fifo_q[0], mon_cyc + 2});
    end
  end

  vec_t          vecs [7];
  int            strobes;
  int            seen_aa;
  int            got_bb;
  logic          hit;
  logic [DW-1:0] got [$];

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    vecs[1] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
    vecs[2] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 16'd0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 16'd1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33, 16'd2};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 16'd3};

    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    #2;
    check_output("reset_out_valid", 32'(dif.out_valid), 32'd0);
    check_output("reset_out_data", 32'(dif.out_data), 32'd0);
    check_output("reset_words_out", 32'(words_out), 32'd0);
    check_output("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    check_output("reset_read_ctrl", 32'(dif.fifo_read_ctrl), 32'd0);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b0, vecs[i].ready, 1'b0, vecs[i].push_en, vecs[i].push_data);
      check_output($sformatf("vec%0d_read_ctrl", i), 32'(dif.fifo_read_ctrl), 32'(vecs[i].exp_rd));
      check_output($sformatf("vec%0d_out_valid", i), 32'(dif.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check_output($sformatf("vec%0d_out_data", i), 32'(dif.out_data), 32'(vecs[i].exp_data));
      check_output($sformatf("vec%0d_words_out", i), 32'(words_out), 32'(vecs[i].exp_words));
    end

    strobes = 0;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, i < 5, 8'hA1 + 8'(i));
      if (dif.fifo_read_ctrl) strobes++;
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("backpressure_strobes", 32'(strobes), 32'(DEPTH));
    check_output("backpressure_valid", 32'(dif.out_valid), 32'd1);
    check_output("backpressure_data", 32'(dif.out_data), 32'hA1);
    check_output("backpressure_stalls", 32'(stall_cycles), STATS ? 32'd4 : 32'd0);
    got.delete();
    for (int k = 0; k < 20 && words_out != 16'd8; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      if (dif.out_valid) got.push_back(dif.out_data);
    end
    check_output("drain_words_out", 32'(words_out), 32'd8);
    check_output("drain_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < got.size(); k++)
      check_output($sformatf("drain_order%0d", k), 32'(got[k]), 32'(8'hA1 + 8'(k)));

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      check_output("empty_no_read", 32'(dif.fifo_read_ctrl), 32'd0);
      check_output("empty_no_valid", 32'(dif.out_valid), 32'd0);
    end

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA);
    check_output("flush_pre_read", 32'(dif.fifo_read_ctrl), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_output("flush_strobe_aa", 32'(dif.fifo_read_ctrl), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hBB);
    check_output("flush_blocks_read", 32'(dif.fifo_read_ctrl), 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check_output("flush_valid_low", 32'(dif.out_valid), 32'd0);
    check_output("flush_strobe_bb", 32'(dif.fifo_read_ctrl), 32'd1);
    seen_aa = 0;
    got_bb  = 0;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      if (dif.out_valid && dif.out_data == 8'hAA) seen_aa++;
      if (dif.out_valid && dif.out_data == 8'hBB) got_bb++;
    end
    check_output("flush_aa_dropped", 32'(seen_aa), 32'd0);
    check_output("flush_bb_delivered", 32'(got_bb), 32'd1);
    check_output("flush_words_out", 32'(words_out), 32'd9);

    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 1'b0, i < 4, 8'hC1 + 8'(i));
    check_output("prereset_valid", 32'(dif.out_valid), 32'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("midreset_read_ctrl", 32'(dif.fifo_read_ctrl), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("postreset_valid", 32'(dif.out_valid), 32'd0);
    check_output("postreset_words_out", 32'(words_out), 32'd0);
    check_output("postreset_stalls", 32'(stall_cycles), 32'd0);

    for (int i = 0; i < 3000; i++)
      apply_stimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, 8'($urandom));

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    hit = 1'b0;
    for (int i = 0; i < 65545 && !hit; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
      if (words_out == 16'hFFFF) hit = 1'b1;
    end
    check_output("wrap_reached_ffff", 32'(hit), 32'd1);
    check_output("wrap_valid", 32'(dif.out_valid), 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'($urandom));
    check_output("wrap_to_zero", 32'(words_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
